// File: rtl/operand2_sequencer_if.sv
// Bus bundle for operand2_sequencer.
//   Instruction handshake : in_valid, in_ready, instr
//   Register-file read    : rf_re, rf_addr, rf_data (combinational read data)
//   Shifter operands      : out_valid, out_ready, shift_type, shift_num,
//                           not_shift, x, rrx
// Modport slave is the sequencer's view.
// Modport master is the surrounding environment's view: it feeds
// instructions, returns register data and consumes operands.
interface operand2_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        rf_re;
    logic [3:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  shift_type;
    logic [7:0]  shift_num;
    logic        not_shift;
    logic [31:0] x;
    logic        rrx;

    modport slave (
        input  in_valid, instr, rf_data, out_ready,
        output in_ready, rf_re, rf_addr, out_valid,
               shift_type, shift_num, not_shift, x, rrx
    );

    modport master (
        output in_valid, instr, rf_data, out_ready,
        input  in_ready, rf_re, rf_addr, out_valid,
               shift_type, shift_num, not_shift, x, rrx
    );
endinterface

// File: rtl/operand2_sequencer.sv
// operand2_sequencer: turns the operand2 field of a data-processing
// instruction into shifter operands.
//   - Immediate form (I=1): 8-bit value rotated right by 2*rot.
//   - Immediate shift (I=0, bit4=0): reads Rm, then the shift amount
//     comes from the instruction.
//   - Register shift (I=0, bit4=1): reads Rm, then reads Rs for the
//     amount.
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : operand2_sequencer_if.slave (instruction handshake,
//             register-file read port, shifter operand handshake)
// All operand outputs, rf_re and rf_addr are registered. in_ready is
// combinational because it must follow out_ready while in OUT. That
// allows a new instruction to be accepted in the same cycle the
// downstream stage consumes the current operands.
module operand2_sequencer (
    input  logic                  clk,
    input  logic                  reset_n,
    operand2_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        READ_RM = 2'd1,
        READ_RS = 2'd2,
        OUT     = 2'd3
    } state_t;

    state_t      state_r;
    logic [11:0] op2_r;          // latched operand2 field of the instruction
    logic        out_valid_r;
    logic        rf_re_r;
    logic [3:0]  rf_addr_r;
    logic [1:0]  shift_type_r;
    logic [7:0]  shift_num_r;
    logic        not_shift_r;
    logic        rrx_r;
    logic [31:0] x_r;

    logic        in_ready_s;
    logic        accept_s;
    logic [7:0]  imm_num_s;
    logic        imm_not_shift_s;
    logic        imm_rrx_s;

    // Ready when idle, or when the operands on display leave this cycle.
    always_comb begin
        in_ready_s = 1'b0;
        if (state_r == IDLE) begin
            in_ready_s = 1'b1;
        end else if (state_r == OUT) begin
            in_ready_s = bus.out_ready;
        end else begin
            in_ready_s = 1'b0;
        end
    end

    assign accept_s = bus.in_valid && in_ready_s;

    // Decode the shift-by-immediate special encodings of the latched operand2.
    // An amount of zero means: LSL -> no shift, LSR/ASR -> 32, ROR -> RRX.
    always_comb begin
        imm_num_s       = {3'b000, op2_r[11:7]};
        imm_not_shift_s = 1'b0;
        imm_rrx_s       = 1'b0;
        if (op2_r[11:7] == 5'd0) begin
            case (op2_r[6:5])
                2'b00: imm_not_shift_s = 1'b1;
                2'b01,
                2'b10: imm_num_s = 8'd32;
                2'b11: begin
                    imm_rrx_s       = 1'b1;
                    imm_not_shift_s = 1'b1;
                end
                default: imm_num_s = 8'd0;
            endcase
        end else begin
            imm_num_s = {3'b000, op2_r[11:7]};
        end
    end

    // Sequencer FSM with registered operand, strobe and address outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            op2_r        <= 12'd0;
            out_valid_r  <= 1'b0;
            rf_re_r      <= 1'b0;
            rf_addr_r    <= 4'd0;
            shift_type_r <= 2'd0;
            shift_num_r  <= 8'd0;
            not_shift_r  <= 1'b0;
            rrx_r        <= 1'b0;
            x_r          <= 32'd0;
        end else if (accept_s) begin
            // Accept in IDLE or in OUT with out_ready: no bubble either way.
            op2_r <= bus.instr[11:0];
            if (bus.instr[25]) begin
                state_r      <= OUT;
                out_valid_r  <= 1'b1;
                rf_re_r      <= 1'b0;
                rf_addr_r    <= 4'd0;
                x_r          <= {24'd0, bus.instr[7:0]};
                shift_type_r <= 2'b11;
                shift_num_r  <= {3'b000, bus.instr[11:8], 1'b0};
                not_shift_r  <= (bus.instr[11:8] == 4'd0);
                rrx_r        <= 1'b0;
            end else begin
                // The Rm read is issued in the cycle the FSM sits in READ_RM.
                state_r     <= READ_RM;
                out_valid_r <= 1'b0;
                rf_re_r     <= 1'b1;
                rf_addr_r   <= bus.instr[3:0];
            end
        end else begin
            case (state_r)
                IDLE: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                end
                READ_RM: begin
                    x_r          <= bus.rf_data;
                    shift_type_r <= op2_r[6:5];
                    if (op2_r[4]) begin
                        state_r   <= READ_RS;
                        rf_re_r   <= 1'b1;
                        rf_addr_r <= op2_r[11:8];
                    end else begin
                        state_r     <= OUT;
                        out_valid_r <= 1'b1;
                        rf_re_r     <= 1'b0;
                        rf_addr_r   <= 4'd0;
                        shift_num_r <= imm_num_s;
                        not_shift_r <= imm_not_shift_s;
                        rrx_r       <= imm_rrx_s;
                    end
                end
                READ_RS: begin
                    state_r     <= OUT;
                    out_valid_r <= 1'b1;
                    rf_re_r     <= 1'b0;
                    rf_addr_r   <= 4'd0;
                    shift_num_r <= bus.rf_data[7:0];
                    not_shift_r <= (bus.rf_data[7:0] == 8'd0);
                    rrx_r       <= 1'b0;
                end
                OUT: begin
                    // Operands hold; only the valid flag drops once consumed.
                    if (bus.out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                    end else begin
                        state_r     <= OUT;
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    rf_re_r     <= 1'b0;
                    rf_addr_r   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.rf_re      = rf_re_r;
    assign bus.rf_addr    = rf_addr_r;
    assign bus.shift_type = shift_type_r;
    assign bus.shift_num  = shift_num_r;
    assign bus.not_shift  = not_shift_r;
    assign bus.rrx        = rrx_r;
    assign bus.x          = x_r;
endmodule

// File: tb/tb_operand2_sequencer.sv
// Scoreboard bench for operand2_sequencer: the driver pushes expected
// operands/read addresses on accept; the monitor pops and compares whenever
// the DUT presents operands or a register read.
module tb_operand2_sequencer;
    logic clk;
    logic reset_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    logic front_seen;

    logic [31:0] rf_mem [16];

    typedef struct packed {
        logic [31:0] x;
        logic [1:0]  t;
        logic [7:0]  n;
        logic        ns;
        logic        rrx;
        int          due;
    } exp_t;

    exp_t       sb_q [$];
    logic [3:0] rd_q [$];

    operand2_sequencer_if bus ();

    operand2_sequencer dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.rf_data = rf_mem[bus.rf_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: operand2 semantics computed directly from the fields.
    function automatic exp_t model(input logic [31:0] ins, input int now);
        exp_t e;
        int   amt;
        e.rrx = 1'b0;
        if (ins[25]) begin
            e.x   = {24'd0, ins[7:0]};
            e.t   = 2'b11;
            e.n   = 8'(int'(ins[11:8]) * 2);
            e.ns  = (ins[11:8] == 4'd0);
            e.due = now + 1;
        end else begin
            e.x = rf_mem[ins[3:0]];
            e.t = ins[6:5];
            if (ins[4]) begin
                e.n   = rf_mem[ins[11:8]][7:0];
                e.ns  = (e.n == 8'd0);
                e.due = now + 3;
            end else begin
                amt  = int'(ins[11:7]);
                e.n  = 8'(amt);
                e.ns = 1'b0;
                if (amt == 0) begin
                    if (ins[6:5] == 2'b00) e.ns = 1'b1;
                    else if (ins[6:5] == 2'b11) begin e.rrx = 1'b1; e.ns = 1'b1; end
                    else e.n = 8'd32;
                end
                e.due = now + 2;
            end
        end
        return e;
    endfunction

    task automatic issue(input logic v, input logic [31:0] ins, input logic ordy, output logic acc);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (acc) begin
            sb_q.push_back(model(ins, cyc));
            if (!ins[25]) begin
                rd_q.push_back(ins[3:0]);
                if (ins[4]) rd_q.push_back(ins[11:8]);
            end
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic ordy, output logic acc);
        @(negedge clk);
        issue(v, ins, ordy, acc);
    endtask

    task automatic drain();
        logic acc;
        for (int i = 0; i < 30; i++) begin
            if (sb_q.size() == 0 && rd_q.size() == 0) break;
            drive(1'b0, 32'd0, 1'b1, acc);
        end
        chk("drain_sb_empty", sb_q.size(), 32'd0);
        chk("drain_rd_empty", rd_q.size(), 32'd0);
    endtask

    // Monitor: compare every presented operand set and every register read.
    initial begin
        exp_t e;
        front_seen = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset_n) begin
                if (bus.rf_re) begin
                    if (rd_q.size() == 0) begin
                        chk("unexpected_rf_re", {31'd0, bus.rf_re}, 32'd0);
                    end else begin
                        chk("rf_addr", {28'd0, bus.rf_addr}, {28'd0, rd_q.pop_front()});
                    end
                end else begin
                    chk("rf_addr_idle_zero", {28'd0, bus.rf_addr}, 32'd0);
                end
                if (bus.out_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("unexpected_out_valid", {31'd0, bus.out_valid}, 32'd0);
                    end else begin
                        e = sb_q[0];
                        chk("x", bus.x, e.x);
                        chk("shift_type", {30'd0, bus.shift_type}, {30'd0, e.t});
                        chk("shift_num", {24'd0, bus.shift_num}, {24'd0, e.n});
                        chk("not_shift", {31'd0, bus.not_shift}, {31'd0, e.ns});
                        chk("rrx", {31'd0, bus.rrx}, {31'd0, e.rrx});
                        chk("rf_re_in_out", {31'd0, bus.rf_re}, 32'd0);
                        if (!front_seen) chk("latency", cyc, e.due);
                        front_seen = 1'b1;
                        if (bus.out_ready) begin
                            void'(sb_q.pop_front());
                            front_seen = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic [31:0] ins;
        n_tests       = 0;
        n_fail        = 0;
        cyc           = 0;
        reset_n       = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = 32'd0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 16; i++) rf_mem[i] = $urandom;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_rf_re", {31'd0, bus.rf_re}, 32'd0);
        chk("rst_rf_addr", {28'd0, bus.rf_addr}, 32'd0);
        chk("rst_x", bus.x, 32'd0);
        chk("rst_shift_num", {24'd0, bus.shift_num}, 32'd0);
        chk("rst_shift_type", {30'd0, bus.shift_type}, 32'd0);
        chk("rst_not_shift", {31'd0, bus.not_shift}, 32'd0);
        chk("rst_rrx", {31'd0, bus.rrx}, 32'd0);

        // First edge after release must accept: immediate 0xFF ror 8.
        @(negedge clk);
        reset_n = 1'b1;
        issue(1'b1, 32'h0200_04FF, 1'b1, acc);
        chk("accept_after_reset", {31'd0, acc}, 32'd1);
        drain();

        // Immediate shift LSR #0 from r2.
        rf_mem[2] = 32'h8000_0000;
        drive(1'b1, 32'h0000_0022, 1'b1, acc);
        chk("accept_lsr0", {31'd0, acc}, 32'd1);
        drain();

        // Register shift: Rm=r1, Rs=r3.
        rf_mem[1] = 32'h1234_5678;
        rf_mem[3] = 32'h0000_0104;
        drive(1'b1, 32'h0000_0311, 1'b1, acc);
        chk("accept_regshift", {31'd0, acc}, 32'd1);
        drain();

        // LSL #0 and ROR #0 back to back.
        drive(1'b1, 32'h0000_0005, 1'b1, acc);
        drain();
        drive(1'b1, 32'h0000_0065, 1'b1, acc);
        drain();

        // Back-pressure for 5 cycles, then consume with a simultaneous accept.
        drive(1'b1, 32'h0200_0A37, 1'b0, acc);
        chk("accept_stall_item", {31'd0, acc}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'd0, 1'b0, acc);
            chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
        end
        drive(1'b1, 32'h0000_0311, 1'b1, acc);
        chk("no_bubble_accept", {31'd0, acc}, 32'd1);
        drain();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 16; i++) begin
            rf_mem[i] = $urandom;
            if (i % 4 == 0) rf_mem[i][7:0] = 8'd0;
        end
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            if ($urandom_range(3) == 0) ins[11:7] = 5'd0;
            if ($urandom_range(3) == 0) ins[11:8] = 4'd0;
            drive(($urandom_range(9) < 7) ? 1'b1 : 1'b0, ins,
                  ($urandom_range(9) < 6) ? 1'b1 : 1'b0, acc);
        end
        drain();

        // Reset while in READ_RS: operation aborts, nothing stale afterwards.
        drive(1'b1, 32'h0000_0F17, 1'b1, acc);
        drive(1'b0, 32'd0, 1'b1, acc);
        @(negedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midreset_rf_re", {31'd0, bus.rf_re}, 32'd0);
        sb_q.delete();
        rd_q.delete();
        front_seen = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'd0, 1'b1, acc);
        chk("post_reset_no_valid", {31'd0, bus.out_valid}, 32'd0);
        drive(1'b1, 32'h0200_0000, 1'b1, acc);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/operand2_sequencer.md
OPERAND2_SEQUENCER -- requirements
Module: operand2_sequencer

Interface
REQ-001 Parameters: none; data width fixed at 32, register address width fixed at 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  instr holds a data-processing instruction.
REQ-005 in_ready  output  1  sequencer accepts instr this cycle.
REQ-006 instr  input  32  instruction; uses [25] I, [11:0] operand2.
REQ-007 rf_re  output  1  register-file read strobe.
REQ-008 rf_addr  output  4  register-file read address.
REQ-009 rf_data  input  32  combinational read data for rf_addr, same cycle.
REQ-010 out_valid  output  1  shifter operands below are valid.
REQ-011 out_ready  input  1  downstream shifter stage consumes operands.
REQ-012 shift_type  output  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-013 shift_num  output  8  shift amount.
REQ-014 not_shift  output  1  pass x through unshifted.
REQ-015 x  output  32  value to shift.
REQ-016 rrx  output  1  operand is RRX; downstream inserts carry.

Function
REQ-017 The FSM SHALL have states IDLE, READ_RM, READ_RS, OUT.
REQ-018 in_ready SHALL be 1 in IDLE, or in OUT while out_ready=1; 0 otherwise.
REQ-019 Accept = in_valid && in_ready; the instruction SHALL be latched internally on accept.
REQ-020 On accept with I=1, next state SHALL be OUT; x={24'b0,instr[7:0]}, shift_type=11, shift_num={3'b0,instr[11:8],1'b0}, not_shift=(instr[11:8]==0), rrx=0.
REQ-021 On accept with I=0, next state SHALL be READ_RM.
REQ-022 In READ_RM, rf_re=1, rf_addr=latched instr[3:0]; x SHALL capture rf_data.
REQ-023 From READ_RM with latched bit4=0, next state SHALL be OUT; shift_type=instr[6:5], shift_num={3'b0,instr[11:7]}.
REQ-024 Immediate-shift special cases: LSL #0 -> not_shift=1; LSR/ASR #0 -> shift_num=32; ROR #0 -> rrx=1, not_shift=1; otherwise not_shift=0, rrx=0.
REQ-025 From READ_RM with latched bit4=1, next state SHALL be READ_RS.
REQ-026 In READ_RS, rf_re=1, rf_addr=latched instr[11:8]; shift_num=rf_data[7:0], shift_type=instr[6:5], not_shift=(rf_data[7:0]==0), rrx=0; next state OUT.
REQ-027 rf_re SHALL be 0 in IDLE and OUT; rf_addr SHALL be 0 when rf_re=0.
REQ-028 out_valid SHALL be 1 exactly in OUT.
REQ-029 All operand outputs SHALL be registered and held stable while out_valid=1 and out_ready=0.
REQ-030 In OUT with out_ready=1 and no accept, next state SHALL be IDLE; operand outputs SHALL hold.
REQ-031 In OUT with out_ready=1 and simultaneous accept, the new instruction SHALL start with no bubble, as REQ-020/021.
REQ-032 Latency accept->out_valid: 1 cycle immediate, 2 cycles immediate-shift, 3 cycles register-shift.

Reset
REQ-033 While reset_n=0: state IDLE; out_valid, rf_re, rrx, not_shift=0; shift_type, shift_num, x, rf_addr, latched instr=0.
REQ-034 Reset mid-operation SHALL abort; no partial operand is ever presented after release.
REQ-035 The first rising clk after reset_n deasserts SHALL be able to accept (in_ready=1).

Verification
REQ-036 Immediate instr[25]=1, [11:8]=4, [7:0]=FF -> next cycle out_valid=1, x=0x000000FF, type=11, num=8, not_shift=0, rf_re never 1.
REQ-037 Imm-shift LSR #0, Rm=r2, rf_data=0x80000000 -> rf_addr=2 one cycle, then x=0x80000000, type=01, num=32, not_shift=0.
REQ-038 Reg-shift Rm=r1 (0x12345678), Rs=r3 (0x00000104) -> rf_addr 1 then 3, out_valid on cycle 3, x=0x12345678, num=0x04.
REQ-039 out_ready=0 for 5 cycles in OUT -> outputs constant, in_ready=0; then out_ready=1 with in_valid=1 -> accept that cycle, no idle cycle.
REQ-040 reset_n=0 during READ_RS -> out_valid=0 immediately; after release in_ready=1, no stale out_valid.
REQ-041 LSL #0 -> not_shift=1, rrx=0; ROR #0 -> rrx=1, not_shift=1.
